// File: rtl/arith_fsign_pipe.sv
// arith_fsign_pipe: elastic pipelined floating-point sign manipulation.
// Ops: 00 neg, 01 abs, 10 copysign, 11 negcopysign. Only the sign bit is
// touched; exponent and mantissa (including NaN payloads) pass through as-is.
// Each stage is a valid bit plus payload. A stage loads whenever it is empty
// or the stage after it advances, so any empty stage absorbs a bubble.
module arith_fsign_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_is_nan,
    output logic             out_is_zero
);

    localparam int EXP_W = (WIDTH == 16) ? 5 : ((WIDTH == 32) ? 8 : 11);
    localparam int MAN_W = WIDTH - 1 - EXP_W;

    if (!(WIDTH == 16 || WIDTH == 32 || WIDTH == 64)) begin : g_bad_width
        $fatal(1, "arith_fsign_pipe: WIDTH must be 16, 32 or 64");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $fatal(1, "arith_fsign_pipe: LATENCY must be in 1..4");
    end

    // Exponent all-ones with a nonzero mantissa.
    function automatic logic calc_is_nan(input logic [WIDTH-1:0] r);
        return (r[WIDTH-2:MAN_W] == {EXP_W{1'b1}}) && (r[MAN_W-1:0] != {MAN_W{1'b0}});
    endfunction

    // Every bit except the sign is zero.
    function automatic logic calc_is_zero(input logic [WIDTH-1:0] r);
        return r[WIDTH-2:0] == {(WIDTH-1){1'b0}};
    endfunction

    logic             sign_s;
    logic [WIDTH-1:0] res_s;
    logic             nan_s;
    logic             zero_s;
    logic [LATENCY:0] ready_s;

    logic             v_r    [LATENCY];
    logic [WIDTH-1:0] res_r  [LATENCY];
    logic             nan_r  [LATENCY];
    logic             zero_r [LATENCY];

    // Select the new sign bit from the op code.
    always_comb begin
        sign_s = in_a[WIDTH-1];
        case (in_op)
            2'b00:   sign_s = ~in_a[WIDTH-1];
            2'b01:   sign_s = 1'b0;
            2'b10:   sign_s = in_b[WIDTH-1];
            2'b11:   sign_s = ~in_b[WIDTH-1];
            default: sign_s = in_a[WIDTH-1];
        endcase
    end

    // Result and its classification, computed ahead of stage 0.
    always_comb begin
        res_s  = {sign_s, in_a[WIDTH-2:0]};
        nan_s  = calc_is_nan(res_s);
        zero_s = calc_is_zero(res_s);
    end

    // Stage k is ready when out_ready is high or any stage from k onward is empty.
    always_comb begin
        logic acc;
        ready_s          = {(LATENCY+1){1'b0}};
        ready_s[LATENCY] = out_ready;
        acc              = out_ready;
        for (int k = LATENCY - 1; k >= 0; k--) begin
            acc        = acc | ~v_r[k];
            ready_s[k] = acc;
        end
    end

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        logic             up_v_s;
        logic [WIDTH-1:0] up_res_s;
        logic             up_nan_s;
        logic             up_zero_s;

        if (k == 0) begin : g_head
            assign up_v_s    = in_valid;
            assign up_res_s  = res_s;
            assign up_nan_s  = nan_s;
            assign up_zero_s = zero_s;
        end else begin : g_body
            assign up_v_s    = v_r[k-1];
            assign up_res_s  = res_r[k-1];
            assign up_nan_s  = nan_r[k-1];
            assign up_zero_s = zero_r[k-1];
        end

        // Stage register: take the upstream bundle whenever this slot can move.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r[k]    <= 1'b0;
                res_r[k]  <= {WIDTH{1'b0}};
                nan_r[k]  <= 1'b0;
                zero_r[k] <= 1'b0;
            end else if (ready_s[k]) begin
                v_r[k] <= up_v_s;
                if (up_v_s) begin
                    res_r[k]  <= up_res_s;
                    nan_r[k]  <= up_nan_s;
                    zero_r[k] <= up_zero_s;
                end
            end
        end
    end

    assign in_ready    = ready_s[0];
    assign out_valid   = v_r[LATENCY-1];
    assign out_result  = res_r[LATENCY-1];
    assign out_is_nan  = nan_r[LATENCY-1];
    assign out_is_zero = zero_r[LATENCY-1];

endmodule
